lemming_crowd_fsm: RTL and testbench



---
 rtl/lemming_pkg.sv | 24 ++
 rtl/lemming_lane.sv | 92 +++++++++
 rtl/lemming_crowd_fsm.sv | 60 ++++++
 tb/tb_lemming_crowd_fsm.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/lemming_pkg.sv
// Shared types and helpers for the multi-lane walker crowd controller.
// LEMMING_DIG_EN adds the DIG_L/DIG_R states to the state encoding.
package lemming_pkg;

    localparam int DEFAULT_FALL_LIMIT = 20;

    typedef enum logic [2:0] {
        WALK_L = 3'd0,
        WALK_R = 3'd1,
        FALL_L = 3'd2,
        FALL_R = 3'd3,
`ifdef LEMMING_DIG_EN
        DIG_L  = 3'd4,
        DIG_R  = 3'd5,
`endif
        SPLAT  = 3'd6
    } lemming_state_t;

    // Counter must hold FALL_LIMIT+1 so a too-long fall is distinguishable.
    function automatic int fall_cnt_width(input int limit);
        return $clog2(limit + 2);
    endfunction

endpackage

// File: rtl/lemming_lane.sv
// One walker: Moore FSM plus saturating fall counter.
// LEMMING_DIG_EN enables the dig branch and the digging output.
module lemming_lane
    import lemming_pkg::*;
#(
    parameter int FALL_LIMIT = DEFAULT_FALL_LIMIT
) (
    input  logic clk,
    input  logic areset_n,
    input  logic bump_left,
    input  logic bump_right,
    input  logic ground,
    input  logic dig,
    output logic walk_left,
    output logic walk_right,
    output logic aaah,
    output logic digging,
    output logic splat,
    output logic is_alive_next
);

    localparam int CW = fall_cnt_width(FALL_LIMIT);
    localparam logic [CW-1:0] CNT_LIM = CW'(FALL_LIMIT);
    localparam logic [CW-1:0] CNT_SAT = CW'(FALL_LIMIT + 1);

    lemming_state_t r_state, w_state_nxt;
    logic [CW-1:0]  r_fall_cnt, w_fall_cnt_nxt;
    logic           w_in_fall, w_nxt_fall;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_state    <= WALK_L;
            r_fall_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fall_cnt <= w_fall_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            WALK_L: begin
                if (!ground)        w_state_nxt = FALL_L;
`ifdef LEMMING_DIG_EN
                else if (dig)       w_state_nxt = DIG_L;
`endif
                else if (bump_left) w_state_nxt = WALK_R;
            end
            WALK_R: begin
                if (!ground)         w_state_nxt = FALL_R;
`ifdef LEMMING_DIG_EN
                else if (dig)        w_state_nxt = DIG_R;
`endif
                else if (bump_right) w_state_nxt = WALK_L;
            end
            FALL_L: if (ground) w_state_nxt = (r_fall_cnt >= CNT_LIM) ? SPLAT : WALK_L;
            FALL_R: if (ground) w_state_nxt = (r_fall_cnt >= CNT_LIM) ? SPLAT : WALK_R;
`ifdef LEMMING_DIG_EN
            DIG_L:  if (!ground) w_state_nxt = FALL_L;
            DIG_R:  if (!ground) w_state_nxt = FALL_R;
`endif
            SPLAT:  w_state_nxt = SPLAT;
            default: w_state_nxt = WALK_L;
        endcase
    end

    // Count holds cycles already completed in this fall; zero everywhere else.
    assign w_in_fall  = (r_state == FALL_L) || (r_state == FALL_R);
    assign w_nxt_fall = (w_state_nxt == FALL_L) || (w_state_nxt == FALL_R);

    always_comb begin
        w_fall_cnt_nxt = '0;
        if (w_in_fall && w_nxt_fall)
            w_fall_cnt_nxt = (r_fall_cnt == CNT_SAT) ? r_fall_cnt : r_fall_cnt + 1'b1;
    end

    assign walk_left     = (r_state == WALK_L);
    assign walk_right    = (r_state == WALK_R);
    assign aaah          = w_in_fall;
    assign splat         = (r_state == SPLAT);
    assign is_alive_next = (w_state_nxt != SPLAT);

`ifdef LEMMING_DIG_EN
    assign digging = (r_state == DIG_L) || (r_state == DIG_R);
`else
    logic w_dig_unused;
    assign w_dig_unused = dig;
    assign digging      = 1'b0;
`endif

endmodule

// File: rtl/lemming_crowd_fsm.sv
// NUM_LANES independent walkers plus a registered count of survivors.
// Dig behaviour is controlled by LEMMING_DIG_EN inside lemming_lane.
module lemming_crowd_fsm
    import lemming_pkg::*;
#(
    parameter int NUM_LANES  = 4,
    parameter int FALL_LIMIT = DEFAULT_FALL_LIMIT
) (
    input  logic                           clk,
    input  logic                           areset_n,
    input  logic [NUM_LANES-1:0]           bump_left,
    input  logic [NUM_LANES-1:0]           bump_right,
    input  logic [NUM_LANES-1:0]           ground,
    input  logic [NUM_LANES-1:0]           dig,
    output logic [NUM_LANES-1:0]           walk_left,
    output logic [NUM_LANES-1:0]           walk_right,
    output logic [NUM_LANES-1:0]           aaah,
    output logic [NUM_LANES-1:0]           digging,
    output logic [NUM_LANES-1:0]           splat,
    output logic [$clog2(NUM_LANES+1)-1:0] alive_cnt
);

    localparam int AW = $clog2(NUM_LANES + 1);

    logic [NUM_LANES-1:0] w_alive_nxt;
    logic [AW-1:0]        w_alive_sum;
    logic [AW-1:0]        r_alive_cnt;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        lemming_lane #(.FALL_LIMIT(FALL_LIMIT)) u_lane (
            .clk           (clk),
            .areset_n      (areset_n),
            .bump_left     (bump_left[i]),
            .bump_right    (bump_right[i]),
            .ground        (ground[i]),
            .dig           (dig[i]),
            .walk_left     (walk_left[i]),
            .walk_right    (walk_right[i]),
            .aaah          (aaah[i]),
            .digging       (digging[i]),
            .splat         (splat[i]),
            .is_alive_next (w_alive_nxt[i])
        );
    end

    // Summing next-state liveness keeps alive_cnt aligned with the state edge.
    always_comb begin
        w_alive_sum = '0;
        for (int i = 0; i < NUM_LANES; i++)
            w_alive_sum = w_alive_sum + AW'(w_alive_nxt[i]);
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) r_alive_cnt <= AW'(NUM_LANES);
        else           r_alive_cnt <= w_alive_sum;
    end

    assign alive_cnt = r_alive_cnt;

endmodule

// File: tb/tb_lemming_crowd_fsm.sv
// Directed plan items plus randomized lanes against a behavioural walker model.
module tb_lemming_crowd_fsm;

    localparam int NL = 4;
    localparam int FL = 20;
    localparam int AW = $clog2(NL + 1);
`ifdef LEMMING_DIG_EN
    localparam bit DIG_EN = 1'b1;
`else
    localparam bit DIG_EN = 1'b0;
`endif
    localparam int M_WALK = 0, M_FALL = 1, M_DIG = 2, M_SPLAT = 3;

    logic          clk = 1'b0;
    logic          areset_n;
    logic [NL-1:0] bump_left, bump_right, ground, dig;
    logic [NL-1:0] walk_left, walk_right, aaah, digging, splat;
    logic [AW-1:0] alive_cnt;

    always #5 clk = ~clk;

    lemming_crowd_fsm #(.NUM_LANES(NL), .FALL_LIMIT(FL)) dut (
        .clk        (clk),
        .areset_n   (areset_n),
        .bump_left  (bump_left),
        .bump_right (bump_right),
        .ground     (ground),
        .dig        (dig),
        .walk_left  (walk_left),
        .walk_right (walk_right),
        .aaah       (aaah),
        .digging    (digging),
        .splat      (splat),
        .alive_cnt  (alive_cnt)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model: activity, facing direction (0=left) and ground-less samples this fall.
    int m_mode [NL];
    int m_dir  [NL];
    int m_flen [NL];
    int drop_left [NL];
    int lens [6] = '{1, 3, FL - 1, FL, FL + 1, FL + 2};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NL; i++) begin
            m_mode[i] = M_WALK;
            m_dir[i]  = 0;
            m_flen[i] = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < NL; i++) begin
            case (m_mode[i])
                M_WALK: begin
                    if (!ground[i]) begin
                        m_mode[i] = M_FALL;
                        m_flen[i] = 1;
                    end else if (DIG_EN && dig[i]) begin
                        m_mode[i] = M_DIG;
                    end else if (m_dir[i] == 0 ? bump_left[i] : bump_right[i]) begin
                        m_dir[i] = 1 - m_dir[i];
                    end
                end
                M_DIG: if (!ground[i]) begin
                    m_mode[i] = M_FALL;
                    m_flen[i] = 1;
                end
                M_FALL: begin
                    if (!ground[i]) m_flen[i]++;
                    else m_mode[i] = (m_flen[i] > FL) ? M_SPLAT : M_WALK;
                end
                default: ;
            endcase
        end
    endtask

    task automatic check_all();
        logic [NL-1:0] e_wl, e_wr, e_fa, e_dg, e_sp;
        int alive;
        alive = 0;
        for (int i = 0; i < NL; i++) begin
            e_wl[i] = (m_mode[i] == M_WALK) && (m_dir[i] == 0);
            e_wr[i] = (m_mode[i] == M_WALK) && (m_dir[i] == 1);
            e_fa[i] = (m_mode[i] == M_FALL);
            e_dg[i] = (m_mode[i] == M_DIG);
            e_sp[i] = (m_mode[i] == M_SPLAT);
            if (m_mode[i] != M_SPLAT) alive++;
        end
        chk("walk_left",  32'(walk_left),  32'(e_wl));
        chk("walk_right", 32'(walk_right), 32'(e_wr));
        chk("aaah",       32'(aaah),       32'(e_fa));
        chk("digging",    32'(digging),    32'(e_dg));
        chk("splat",      32'(splat),      32'(e_sp));
        chk("alive_cnt",  32'(alive_cnt),  32'(alive));
    endtask

    task automatic cyc(input logic [NL-1:0] bl, input logic [NL-1:0] br,
                       input logic [NL-1:0] g, input logic [NL-1:0] d);
        bump_left  = bl;
        bump_right = br;
        ground     = g;
        dig        = d;
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        areset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("rst_walk_left", 32'(walk_left), 32'({NL{1'b1}}));
        chk("rst_alive",     32'(alive_cnt), NL);
        @(negedge clk);
        areset_n = 1'b1;
    endtask

    initial begin
        logic [NL-1:0] g;
        areset_n   = 1'b1;
        bump_left  = '0;
        bump_right = '0;
        ground     = '1;
        dig        = '0;
        for (int i = 0; i < NL; i++) drop_left[i] = 0;
        #2;
        do_reset();

        repeat (5) cyc('0, '0, '1, '0);

        // Lane 0: turn right on left bump, then both bumps turn it back.
        cyc(4'b0001, 4'b0000, '1, '0);
        cyc(4'b0001, 4'b0001, '1, '0);
        cyc('0, '0, '1, '0);

        // Lane 1: 20-cycle fall survives, 21-cycle fall splats.
        repeat (FL) cyc('0, '0, 4'b1101, '0);
        cyc('0, '0, '1, '0);
        chk("land_alive_wl1", 32'(walk_left[1]), 1);
        repeat (FL + 1) cyc('0, '0, 4'b1101, '0);
        cyc('0, '0, '1, '0);
        chk("splat_alive_cnt", 32'(alive_cnt), NL - 1);
        repeat (3) cyc('1, '1, '0, '1);
        chk("splat_stays", 32'(splat[1]), 1);

        // Lane 3 splats, then async reset lands between clock edges.
        cyc('0, '0, '1, '0);
        repeat (FL + 4) cyc('0, '0, 4'b0111, '0);
        cyc('0, '0, '1, '0);
        @(negedge clk);
        do_reset();

        // Dig requests on all lanes.
        repeat (5) cyc('0, '0, '1, '1);
        repeat (3) cyc(4'b1010, 4'b0101, '1, '0);
        cyc('0, '0, '0, '0);
        cyc('0, '0, '1, '0);
        do_reset();

        // Randomized lanes with fall lengths clustered at the survival boundary.
        for (int c = 0; c < 1500; c++) begin
            if (c % 200 == 199) do_reset();
            for (int i = 0; i < NL; i++) begin
                if (drop_left[i] > 0) begin
                    g[i] = 1'b0;
                    drop_left[i]--;
                end else if ($urandom_range(0, 7) == 0) begin
                    g[i] = 1'b0;
                    drop_left[i] = lens[$urandom_range(0, 5)] - 1;
                end else begin
                    g[i] = 1'b1;
                end
            end
            cyc(NL'($urandom), NL'($urandom), g, NL'($urandom & $urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
